// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill controller.
// Contents: fill FSM state encoding, block geometry constants and the
// mask that turns a byte address into its block base address.
package cache_fill_fsm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int unsigned BLOCK_BYTES   = 16;
    localparam int unsigned OFFSET_BITS   = 4;
    localparam int unsigned WORD_IDX_BITS = 3;

    localparam logic [15:0] BASE_MASK = 16'hFFF0;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// fill_counter: 4-bit word counter used for both the request and the
// receive side of a block fill.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset, clears the count
//   i_clr  - synchronous clear (start of a new fill)
//   i_inc  - increment enable
//   o_cnt  - current count
//   o_tc   - terminal flag, high when o_cnt equals TC
module fill_counter #(
    parameter int unsigned TC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_cnt,
    output logic       o_tc
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == 4'(TC));

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling controller. On a cache miss it requests
// every word of the containing block from pipelined main memory, streams
// the returned words into the data array, writes the tag/valid entry with
// the last word, and holds fsm_busy for the whole fill.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   miss_detected       - lookup missed; held by requester until busy falls
//   miss_address        - byte address of the missing access
//   memory_data(_valid) - in-order read data from memory
//   fsm_busy            - fill in progress (pipeline stall)
//   mem_en, memory_address             - memory read request
//   write_data_array, cache_word_offset,
//   cache_write_data    - data-array write port
//   write_tag_array     - tag/valid write for the block being filled
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_detected,
    input  logic [ADDR_W-1:0]        miss_address,
    input  logic [DATA_W-1:0]        memory_data,
    input  logic                     memory_data_valid,
    output logic                     fsm_busy,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        memory_address,
    output logic                     write_data_array,
    output logic [WORD_IDX_BITS-1:0] cache_word_offset,
    output logic [DATA_W-1:0]        cache_write_data,
    output logic                     write_tag_array
);

    fill_state_t       r_state;
    fill_state_t       w_next;
    logic [ADDR_W-1:0] r_base;

    logic       w_start;
    logic [3:0] w_req_cnt;
    logic       w_req_done;
    logic [3:0] w_rcv_cnt;
    logic       w_rcv_last;

    assign w_start = (r_state == IDLE) && miss_detected;

    fill_counter #(.TC(WORDS_PER_BLOCK)) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start),
        .i_inc (mem_en),
        .o_cnt (w_req_cnt),
        .o_tc  (w_req_done)
    );

    fill_counter #(.TC(WORDS_PER_BLOCK - 1)) u_rcv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start),
        .i_inc (write_data_array),
        .o_cnt (w_rcv_cnt),
        .o_tc  (w_rcv_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_base <= miss_address & ADDR_W'(BASE_MASK);
            end
        end
    end

    always_comb begin
        w_next            = r_state;
        fsm_busy          = 1'b0;
        mem_en            = 1'b0;
        memory_address    = '0;
        write_data_array  = 1'b0;
        cache_word_offset = '0;
        write_tag_array   = 1'b0;
        case (r_state)
            IDLE: begin
                if (miss_detected) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                // Base has its offset bits cleared, so adding 2*req_cnt never
                // carries past the block.
                if (!w_req_done) begin
                    mem_en         = 1'b1;
                    memory_address = r_base + ADDR_W'({w_req_cnt, 1'b0});
                end
                // rcv_cnt[3] guards against writing past the end of the block.
                if (memory_data_valid && !w_rcv_cnt[3]) begin
                    write_data_array  = 1'b1;
                    cache_word_offset = w_rcv_cnt[WORD_IDX_BITS-1:0];
                    if (w_rcv_last) begin
                        write_tag_array = 1'b1;
                        w_next          = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign cache_write_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  cache_word_offset;
    logic [15:0] cache_write_data;
    logic        write_tag_array;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = -1;

    always #5 clk = ~clk;

    cache_fill_fsm #(
        .WORDS_PER_BLOCK (8),
        .ADDR_W          (16),
        .DATA_W          (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .cache_word_offset (cache_word_offset),
        .cache_write_data  (cache_write_data),
        .write_tag_array   (write_tag_array)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic start_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset held (rst=0) or first cycle after release (rst=1): everything zero,
    // even with a stray memory_data_valid.
    task automatic reset_view(input logic rst);
        start_cycle();
        rst_n             = rst;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data_valid = 1'b1;
        memory_data       = 16'h5A5A;
        #2;
        chk("rst_busy",   32'(fsm_busy),          32'd0);
        chk("rst_mem_en", 32'(mem_en),            32'd0);
        chk("rst_addr",   32'(memory_address),    32'd0);
        chk("rst_wda",    32'(write_data_array),  32'd0);
        chk("rst_off",    32'(cache_word_offset), 32'd0);
        chk("rst_tag",    32'(write_tag_array),   32'd0);
    endtask

    task automatic idle_cycle(input logic miss, input logic [15:0] addr,
                              input logic vld, input logic [15:0] data);
        start_cycle();
        rst_n             = 1'b1;
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = vld;
        memory_data       = data;
        #2;
        chk("idle_busy",   32'(fsm_busy),         32'd0);
        chk("idle_mem_en", 32'(mem_en),           32'd0);
        chk("idle_wda",    32'(write_data_array), 32'd0);
        chk("idle_tag",    32'(write_tag_array),  32'd0);
        chk("idle_wdata",  32'(cache_write_data), 32'(data));
    endtask

    // Drives fill cycles 1..N after the miss cycle. Memory returns word k at
    // relative cycle lat+1+k (or lat+1+2k when gapped). If abort_at is
    // non-zero, rst_n is asserted in that cycle and the task returns.
    task automatic run_fill(input logic [15:0] base, input int lat, input bit gap,
                            input bit hold, input logic [15:0] maddr,
                            input logic [15:0] pat, input int abort_at);
        int last;
        last = gap ? lat + 15 : lat + 8;
        for (int r = 1; r <= last; r++) begin
            bit v;
            int k;
            v = 1'b0;
            k = 0;
            if (r > lat) begin
                k = r - lat - 1;
                if (gap) begin
                    v = (k % 2 == 0);
                    k = k / 2;
                end else begin
                    v = 1'b1;
                end
            end
            start_cycle();
            rst_n             = (r != abort_at);
            miss_detected     = hold;
            miss_address      = maddr;
            memory_data_valid = v;
            memory_data       = v ? 16'(pat + 16'(k)) : 16'hDEAD;
            if (r == abort_at) return;
            #2;
            chk("fill_busy",   32'(fsm_busy), 32'd1);
            chk("fill_mem_en", 32'(mem_en),   32'(r <= 8));
            if (r <= 8) chk("fill_addr", 32'(memory_address), 32'(16'(base + 16'(2 * (r - 1)))));
            chk("fill_wda", 32'(write_data_array), 32'(v));
            if (v) begin
                chk("fill_off",   32'(cache_word_offset), 32'(k));
                chk("fill_wdata", 32'(cache_write_data),  32'(16'(pat + 16'(k))));
            end
            chk("fill_tag", 32'(write_tag_array), 32'(v && k == 7));
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data       = 16'h0;
        memory_data_valid = 1'b0;

        // Reset for two cycles with valid pulses, then first cycle after.
        reset_view(1'b0);
        reset_view(1'b0);
        reset_view(1'b1);
        idle_cycle(1'b0, 16'h0000, 1'b1, 16'h1234);

        // Single miss at 0x1236, latency 4, miss held; this is cycle 0.
        idle_cycle(1'b1, 16'h1236, 1'b0, 16'h0000);
        run_fill(16'h1230, 4, 1'b0, 1'b1, 16'h1236, 16'hA000, 0);

        // Cycle 13: busy low, second miss at 0x4008 sampled; gapped returns.
        idle_cycle(1'b1, 16'h4008, 1'b0, 16'h0000);
        run_fill(16'h4000, 2, 1'b1, 1'b1, 16'h4008, 16'hB000, 0);
        idle_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);

        // Address wrap at the top of memory.
        idle_cycle(1'b1, 16'hFFFA, 1'b0, 16'h0000);
        run_fill(16'hFFF0, 3, 1'b0, 1'b0, 16'hFFFA, 16'hC000, 0);
        idle_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);

        // Reset in cycle 7 of a fill, late valid pulses, then a fresh fill.
        idle_cycle(1'b1, 16'h2224, 1'b0, 16'h0000);
        run_fill(16'h2220, 4, 1'b0, 1'b0, 16'h2224, 16'hE000, 7);
        reset_view(1'b1);
        idle_cycle(1'b0, 16'h0000, 1'b1, 16'hE003);
        idle_cycle(1'b0, 16'h0000, 1'b1, 16'hE004);
        idle_cycle(1'b1, 16'h5550, 1'b0, 16'h0000);
        run_fill(16'h5550, 1, 1'b0, 1'b0, 16'h5550, 16'hD000, 0);
        idle_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
